// File: rtl/darkroom_spi_receiver_pkg.sv
// Shared types and constants for the DarkRoom SPI frame receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package darkroom_pkg;

    // Receive state machine encoding
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        RECEIVE   = 2'd2,
        OVERRUN   = 2'd3
    } rx_state_t;

    localparam int FRAME_BYTES_DEF = 32;
    localparam int FRAME_BITS      = 8 * FRAME_BYTES_DEF;
    localparam int CNT_W           = 16;

    // Register map beyond the eight frame words at 0..7
    localparam logic [3:0] ADDR_STATUS = 4'd8;
    localparam logic [3:0] ADDR_FLAGS  = 4'd9;

    // 32-bit word a of a frame; word 0 holds bytes 0..3 with byte 0 in [7:0]
    function automatic logic [31:0] frame_word(input logic [FRAME_BITS-1:0] f,
                                               input logic [2:0] a);
        return f[{a, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/darkroom_spi_receiver_if.sv
// Avalon-MM read-only slave bus between a host and the SPI frame receiver.
// Latency: one wait state per read, driven by the slave.
// Backpressure: slave holds waitrequest for the first cycle of every read.
// Signals: address[3:0] word address, read strobe, readdata[31:0], waitrequest.
interface darkroom_spi_receiver_if;
    logic [3:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (output address, read, input readdata, waitrequest);
    modport slave  (input address, read, output readdata, waitrequest);
endinterface

// File: rtl/darkroom_spi_receiver_sync_edge.sv
// Synchronizes one asynchronous SPI line into clock and flags its edges.
// Latency: SYNC_STAGES cycles to level, edge flags in the same cycle as level.
// Backpressure: none; free-running.
// Ports: clock, reset_n, din (async in), level (synced), rise/fall (one-cycle pulses).
// SYNC_STAGES legal range is 2..4. All flops reset to 0, so a line held high
// across reset shows a rising edge shortly after release; callers must tolerate it.
module spi_slave_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/darkroom_spi_receiver.sv
// SPI mode-0 slave that assembles DarkRoom sensor frames and publishes the latest good one.
// Latency: publish 1 cycle after synced ss_n rise; Avalon reads take one wait state.
// Backpressure: none on SPI (oversampled); Avalon waitrequest high for the first read cycle.
// Ports: clock, reset_n (async, active low); avl (Avalon slave: address, read, readdata,
//        waitrequest); sck_i, ss_n_i, mosi_i (SPI, MSB first); frame_valid_o (publish pulse).
// Build option: define DARKROOM_RX_SNAPSHOT_EN to make a read of address 0 freeze the frame
// so that a 0..7 sweep is coherent across a mid-sweep publish.
module darkroom_spi_receiver
    import darkroom_pkg::*;
#(
    parameter int FRAME_BYTES = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    darkroom_spi_receiver_if.slave avl,
    input  logic                   sck_i,
    input  logic                   ss_n_i,
    input  logic                   mosi_i,
    output logic                   frame_valid_o
);

    localparam int                FRAME_W    = 8 * FRAME_BYTES;
    localparam int                BCNT_W     = $clog2(FRAME_BYTES + 1);
    localparam logic [BCNT_W-1:0] BYTES_FULL = BCNT_W'(FRAME_BYTES);

    // ---------------- input synchronizers ----------------
    logic sck_lvl, sck_rise, sck_fall;
    logic ss_n_lvl, ss_n_rise, ss_n_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clock(clock), .reset_n(reset_n), .din(sck_i),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss_n (
        .clock(clock), .reset_n(reset_n), .din(ss_n_i),
        .level(ss_n_lvl), .rise(ss_n_rise), .fall(ss_n_fall)
    );
    spi_slave_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clock(clock), .reset_n(reset_n), .din(mosi_i),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Mode 0 samples only on sck rise; the other edges are not needed.
    logic unused_edges;
    assign unused_edges = ^{sck_lvl, sck_fall, mosi_rise, mosi_fall};

    // ---------------- receive FSM and frame storage ----------------
    rx_state_t          state;
    logic               armed;      // low only for the first cycle after reset
    logic [2:0]         bit_cnt;
    logic [BCNT_W-1:0]  byte_cnt;
    logic [6:0]         byte_sr;    // first seven bits of the byte in flight
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] latest;
    logic [CNT_W-1:0]   frame_count;
    logic [CNT_W-1:0]   error_count;
    logic               frame_available;
    logic               avail_clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            armed           <= 1'b0;
            bit_cnt         <= '0;
            byte_cnt        <= '0;
            byte_sr         <= '0;
            shadow          <= '0;
            latest          <= '0;
            frame_count     <= '0;
            error_count     <= '0;
            frame_available <= 1'b0;
            frame_valid_o   <= 1'b0;
        end else begin
            frame_valid_o <= 1'b0;
            // A publish later in this block overrides the clear.
            if (avail_clear) begin
                frame_available <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!armed) begin
                        // Leaving reset: the master may be mid-frame, so wait
                        // for ss_n to go high before accepting a new frame.
                        armed <= 1'b1;
                        state <= WAIT_HIGH;
                    end else if (ss_n_fall) begin
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        state    <= RECEIVE;
                    end
                end

                WAIT_HIGH: begin
                    if (ss_n_lvl) begin
                        state <= IDLE;
                    end
                end

                RECEIVE: begin
                    // ss_n rise takes priority; a coincident sck bit is dropped.
                    if (ss_n_rise) begin
                        state <= IDLE;
                        if (bit_cnt == 3'd0 && byte_cnt == BYTES_FULL) begin
                            latest          <= shadow;
                            frame_count     <= frame_count + CNT_W'(1);
                            frame_available <= 1'b1;
                            frame_valid_o   <= 1'b1;
                        end else begin
                            error_count <= error_count + CNT_W'(1);
                        end
                    end else if (sck_rise) begin
                        byte_sr <= {byte_sr[5:0], mosi_lvl};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt == BYTES_FULL) begin
                                state <= OVERRUN;
                            end else begin
                                shadow[{byte_cnt, 3'b000} +: 8] <= {byte_sr, mosi_lvl};
                                byte_cnt <= byte_cnt + BCNT_W'(1);
                            end
                        end
                    end
                end

                OVERRUN: begin
                    if (ss_n_rise) begin
                        error_count <= error_count + CNT_W'(1);
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- Avalon read slave ----------------
    logic        rd_pending;   // high in the data cycle of a read
    logic        rd_addr0;     // the pending read targets address 0
    logic        rd_launch;
    logic [31:0] rd_data_next;

    assign rd_launch       = avl.read && !rd_pending;
    assign avl.waitrequest = rd_launch;
    assign avail_clear     = rd_pending && rd_addr0;

`ifdef DARKROOM_RX_SNAPSHOT_EN
    logic [FRAME_W-1:0] snapshot;
`endif

    always_comb begin
        rd_data_next = '0;
        if (avl.address[3] == 1'b0) begin
`ifdef DARKROOM_RX_SNAPSHOT_EN
            if (avl.address[2:0] == 3'd0) begin
                rd_data_next = frame_word(FRAME_BITS'(latest), 3'd0);
            end else begin
                rd_data_next = frame_word(FRAME_BITS'(snapshot), avl.address[2:0]);
            end
`else
            rd_data_next = frame_word(FRAME_BITS'(latest), avl.address[2:0]);
`endif
        end else if (avl.address == ADDR_STATUS) begin
            rd_data_next = {error_count, frame_count};
        end else if (avl.address == ADDR_FLAGS) begin
            rd_data_next = {31'b0, frame_available};
        end
    end

    // readdata is captured at launch, so a publish on the same edge is not visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending   <= 1'b0;
            rd_addr0     <= 1'b0;
            avl.readdata <= '0;
`ifdef DARKROOM_RX_SNAPSHOT_EN
            snapshot     <= '0;
`endif
        end else begin
            if (rd_launch) begin
                rd_pending   <= 1'b1;
                rd_addr0     <= (avl.address == 4'd0);
                avl.readdata <= rd_data_next;
`ifdef DARKROOM_RX_SNAPSHOT_EN
                if (avl.address == 4'd0) begin
                    snapshot <= latest;
                end
`endif
            end else begin
                rd_pending <= 1'b0;
            end
        end
    end

endmodule

// File: doc/darkroom_spi_receiver.md
Name: darkroom_spi_receiver

Overview:
- SPI slave that receives the 256-bit sensor frames sent by the DarkRoom ESP8266-style SPI transmitter: 8 sensors × 32-bit decoded lighthouse words per frame.
- Oversamples the SPI lines in the system clock domain and assembles 32-byte frames.
- Validates frame length and publishes the latest good frame plus counters over an Avalon-MM read slave.
- Used on the receiving FPGA, or as a loopback checker for the lighthouse tracking SPI link.

Parameters:
- FRAME_BYTES, 32, bytes per frame; frame width is 8*FRAME_BYTES bits.
- SYNC_STAGES, 2, synchronizer flops on each SPI input; legal range 2..4.

Ports:
- clock  in  1  system clock; must be ≥ 8× SCK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  4  Avalon word address.
- read  in  1  Avalon read strobe.
- readdata  out  32  Avalon read data.
- waitrequest  out  1  Avalon wait.
- sck_i  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- ss_n_i  in  1  SPI slave select, active low.
- mosi_i  in  1  SPI data, MSB first per byte.
- frame_valid_o  out  1  one-cycle pulse when a good frame is published.

Behaviour:
- Reset: readdata=0, waitrequest=0, frame_valid_o=0, all counters/flags/buffers=0, rx state IDLE.
- Input path: sck_i, ss_n_i and mosi_i each pass through SYNC_STAGES flops. Edges are detected on the synchronized signals (prev vs current).
- Rx FSM states: IDLE, WAIT_HIGH, RECEIVE, OVERRUN.
  - Reset exit goes to WAIT_HIGH; if ss_n is already high, pass through to IDLE next cycle. This discards a frame that is in progress when reset is released.
  - IDLE: ss_n falling edge → clear bit_cnt(3b) and byte_cnt; go to RECEIVE.
  - RECEIVE: on each sck rising edge, shift mosi into the byte register. The 8th bit writes the byte into shadow[8k+7:8k], where k=byte_cnt, then byte_cnt++. Byte 0 therefore lands in bits [7:0].
  - RECEIVE: a completed byte with byte_cnt==FRAME_BYTES → OVERRUN.
  - ss_n rising edge, valid case: bit_cnt==0 and byte_cnt==FRAME_BYTES → copy shadow into the 256-bit latest register; frame_count++; frame_available=1; frame_valid_o pulses the next cycle; go to IDLE.
  - ss_n rising edge, any other length (including 0 bytes): error_count++, latest unchanged; go to IDLE.
  - OVERRUN: ignore sck; on ss_n rising edge, error_count++ and go to IDLE.
- sck edges are ignored while ss_n is high.
- A simultaneous sck edge and ss_n rising edge: the ss_n edge wins and the bit is dropped.
- Counters: frame_count and error_count are 16-bit and wrap 0xFFFF→0.
- Avalon read, one wait state:
  - Cycle N: read=1 and no read in flight → waitrequest=1; readdata registered.
  - Cycle N+1: waitrequest=0 with readdata valid.
  - Master holds read through N+1; the next read can start at N+2.
  - read with waitrequest high does not re-launch.
- Address map:
  - 0..7: latest word a, i.e. latest[32a+31:32a].
  - 8: {error_count, frame_count}.
  - 9: {31'b0, frame_available}.
  - 10..15: 0.
- frame_available clears on a completed read of address 0. If a publish happens in the same cycle as that clear, set wins.
- A publish concurrent with an Avalon read: readdata returns the pre-publish value.

Optional Feature:
- Macro: DARKROOM_RX_SNAPSHOT_EN.
- Defined: a read of address 0 also copies latest into a 256-bit snapshot register in the same cycle. Addresses 1..7 read from snapshot, so one sweep 0→7 is coherent even if a new frame is published mid-sweep. Address 0 returns latest word 0, which equals snapshot word 0.
- Undefined: addresses 1..7 read latest directly; no snapshot register exists.

Decomposition:
- Package darkroom_pkg holds:
  - Rx FSM state encoding.
  - Address constants: ADDR_STATUS=8, ADDR_FLAGS=9.
  - FRAME_BITS derived localparam.
  - Counter width constant of 16.
- One sub-module, spi_slave_sync_edge: SYNC_STAGES synchronizer plus rise/fall edge detect for a single line. Instantiated three times (sck, ss_n, mosi); only the sck and ss_n edge outputs are used.

Test Plan:
- Valid frame: send 32 bytes 0x00..0x1F, SCK=clock/10 → frame_valid_o pulses once; read addr0=0x03020100, addr7=0x1F1E1D1C, addr8=0x00000001, addr9=1 then 0 after reading addr0.
- Short frame: 31 bytes, then 32 bytes + 3 bits → addr8=0x00020000, latest unchanged, no frame_valid_o pulse.
- Overrun: 33 bytes of 0xAA → error_count=1, latest unchanged; a following good frame publishes normally and addr8=0x00010001.
- Reset mid-frame: assert reset_n low after 10 bytes, release while ss_n low, send 5 more bytes, raise ss_n → no error or frame counted; the next full frame publishes.
- Avalon timing: back-to-back reads of addr 0..9 → each shows exactly one waitrequest cycle, data valid the following cycle; addr 12 reads 0.
- With DARKROOM_RX_SNAPSHOT_EN: read addr0; publish a new frame 0xFF..; read addr5 → old-frame word 5 returned. Without the macro → 0xFFFFFFFF returned.
